// File: rtl/sdp_ram_fifo_ctrl_m.sv
// FIFO controller around an external simple-dual-port RAM with 1-cycle registered read.
// A 2-entry output stage gives first-word-fall-through at full throughput.
module sdp_ram_fifo_ctrl_m #(
   parameter int ADDR_WIDTH = 4,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WORD_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WORD_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [WORD_WIDTH-1:0] ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [WORD_WIDTH-1:0] ram_rdata
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int LW = ADDR_WIDTH + 2;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [PW-1:0]         wptr, rptr, ram_cnt;
   logic                  rd_pend;
   logic [1:0]            occ;
   logic [WORD_WIDTH-1:0] stg0, stg1;
   logic                  push, pop, issue;
   logic [2:0]            credit;

   assign ram_cnt = wptr - rptr;
   assign s_ready = (ram_cnt != DEPTH);
   assign push    = s_valid & s_ready;
   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid & m_ready;

   // Slots the output stage will still owe after this edge; a new read may
   // only be launched if its data is guaranteed a place when it lands.
   assign credit = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
   assign issue  = (ram_cnt != '0) && (credit < 3'd2);

   assign ram_we    = push;
   assign ram_waddr = wptr[ADDR_WIDTH-1:0];
   assign ram_wdata = s_data;
   assign ram_raddr = rptr[ADDR_WIDTH-1:0];
   assign m_data    = stg0;
   assign level     = LW'(ram_cnt) + LW'(rd_pend) + LW'(occ);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         rd_pend <= 1'b0;
         occ     <= 2'd0;
      end else begin
         if (push)
            wptr <= wptr + PW'(1);
         if (issue)
            rptr <= rptr + PW'(1);
         rd_pend <= issue;
         case ({rd_pend, pop})
            2'b10: begin
               if (occ == 2'd0)
                  stg0 <= ram_rdata;
               else
                  stg1 <= ram_rdata;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               stg0 <= stg1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // Head leaves while a word lands: occupancy unchanged, order kept.
               if (occ == 2'd1) begin
                  stg0 <= ram_rdata;
               end else begin
                  stg0 <= stg1;
                  stg1 <= ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl_m.sv
// Directed bench for sdp_ram_fifo_ctrl_m with a behavioural registered-read RAM
// and a queue model tracking word order and occupancy.
module tb_sdp_ram_fifo_ctrl_m;

   logic        clk = 1'b0;
   logic        rst, s_valid, s_ready, m_valid, m_ready;
   logic [31:0] s_data, m_data;
   logic [5:0]  level;
   logic        ram_we;
   logic [3:0]  ram_waddr, ram_raddr;
   logic [31:0] ram_wdata, ram_rdata;
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   sdp_ram_fifo_ctrl_m #(.ADDR_WIDTH(4), .WORD_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .level(level),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   int n_assert = 0, n_fail = 0, n_push = 0, n_pop = 0, lvl_model = 0;
   logic [31:0] q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Sample handshakes mid-cycle, advance one edge, update the model and check level.
   task automatic tick();
      logic p, o, r;
      logic [31:0] d_in, d_out, want;
      @(negedge clk);
      r = rst; p = s_valid & s_ready; o = m_valid & m_ready;
      d_in = s_data; d_out = m_data;
      @(posedge clk); #1;
      if (r) begin
         q.delete();
         lvl_model = 0;
      end else begin
         if (o) begin
            chk("pop_model_empty", 64'(q.size() == 0), 64'd0);
            if (q.size() > 0) begin
               want = q.pop_front();
               chk("m_data_order", d_out, want);
            end
            n_pop++;
         end
         if (p) begin
            q.push_back(d_in);
            n_push++;
         end
         lvl_model = lvl_model + int'(p) - int'(o);
      end
      chk("level", level, 64'(lvl_model));
   endtask

   initial begin
      int base_push, base_pop, cyc, sent;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_s_ready", s_ready, 1);
         chk("idle_m_valid", m_valid, 0);
         chk("idle_level", level, 0);
         chk("idle_ram_we", ram_we, 0);
      end

      // single word latency
      s_valid = 1'b1; s_data = 32'h11; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("lat_e0_m_valid", m_valid, 0);
      chk("lat_e0_level", level, 1);
      tick();
      chk("lat_e1_m_valid", m_valid, 0);
      chk("lat_e1_level", level, 1);
      tick();
      chk("lat_e2_m_valid", m_valid, 1);
      chk("lat_e2_m_data", m_data, 32'h11);
      chk("lat_e2_level", level, 1);
      tick();
      chk("lat_e3_m_valid", m_valid, 0);
      chk("lat_e3_level", level, 0);

      // fill with consumer stalled
      m_ready = 1'b0;
      base_push = n_push;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1; s_data = 32'(i);
         tick();
      end
      s_valid = 1'b0;
      chk("full_accepted", 64'(n_push - base_push), 18);
      chk("full_s_ready", s_ready, 0);
      chk("full_level", level, 18);
      chk("full_m_valid", m_valid, 1);
      chk("full_m_data", m_data, 32'h0);
      m_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         chk("drain_no_bubble", m_valid, 1);
         tick();
      end
      chk("drain_m_valid", m_valid, 0);
      chk("drain_level", level, 0);

      // streaming 100 words
      base_push = n_push; base_pop = n_pop; cyc = 0; sent = 0;
      m_ready = 1'b1;
      while ((n_pop - base_pop) < 100 && cyc < 300) begin
         s_valid = (sent < 100); s_data = 32'(sent);
         if (s_valid) chk("stream_s_ready", s_ready, 1);
         if ((n_pop - base_pop) > 0) chk("stream_no_bubble", m_valid, 1);
         chk("stream_level_max", 64'(level <= 6'd3), 1);
         tick();
         sent = n_push - base_push;
         cyc++;
      end
      s_valid = 1'b0;
      chk("stream_timeout", 64'(cyc >= 300), 0);
      chk("stream_count", 64'(n_push - base_push), 100);

      // random handshakes, 1000 words
      base_push = n_push; base_pop = n_pop; cyc = 0;
      while ((n_pop - base_pop) < 1000 && cyc < 20000) begin
         sent = n_push - base_push;
         s_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         s_data = $urandom;
         m_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      s_valid = 1'b0; m_ready = 1'b1;
      chk("rand_timeout", 64'(cyc >= 20000), 0);
      chk("rand_push_count", 64'(n_push - base_push), 1000);
      tick();
      chk("rand_empty_level", level, 0);

      // reset with a read in flight
      m_ready = 1'b0; s_valid = 1'b1; cyc = 0;
      while (lvl_model < 10 && cyc < 50) begin
         s_data = 32'h100 + 32'(cyc);
         tick();
         cyc++;
      end
      s_valid = 1'b0;
      chk("rstfill_level", level, 10);
      m_ready = 1'b1;
      tick();
      chk("rstfill_level_after_pop", level, 9);
      rst = 1'b1; m_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_level", level, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 1);
      tick();
      chk("rst_no_stale_capture", m_valid, 0);
      s_valid = 1'b1; s_data = 32'hAA; m_ready = 1'b0;
      tick();
      s_valid = 1'b0;
      cyc = 0;
      while (!m_valid && cyc < 5) begin
         tick();
         cyc++;
      end
      chk("post_rst_timeout", 64'(cyc >= 5), 0);
      chk("post_rst_first_word", m_data, 32'hAA);
      m_ready = 1'b1;
      tick();
      chk("post_rst_empty", m_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
